// File: rtl/dmem_responder.sv
// dmem_responder: single-port RV32I data memory behind a valid/ready
// request/response handshake with a programmable access latency.
//
// Parameters:
//   DATA_W  - data width in bits (only 32 is supported)
//   ADDR_W  - byte-address width; the array holds 2^(ADDR_W-2) words
//   LATENCY - clock edges from request accept to rsp_valid high (1..15)
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   req_valid  - core presents a load/store request
//   req_ready  - responder can accept a request (only while idle)
//   req_we     - 1 = store, 0 = load
//   req_funct3 - RV32I funct3 (access size and signedness)
//   req_addr   - byte address
//   req_wdata  - right-aligned store data
//   rsp_valid  - response available, held until rsp_ready
//   rsp_ready  - core consumes the response
//   rsp_rdata  - extended load data, 0 for stores and errored accesses
//   rsp_err    - access error flag
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to report misaligned
// halfword/word accesses and illegal funct3 codes on rsp_err. Without it,
// low address bits below the access size are ignored and rsp_err stays 0.

module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              l_we;
  logic [2:0]        l_funct3;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              a_we;
  logic [2:0]        a_funct3;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [ADDR_W-3:0] word_idx;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] ld_data;
  logic [3:0]        be;
  logic [1:0]        eff_off;
  logic              illegal;
  logic              bad;
  logic              acc_err;
  logic              wr_en;

  assign accept = (state == IDLE) && req_valid;

  // The access happens on the edge that enters RESP. With LATENCY = 1 that
  // is the accept edge itself, so the request inputs must be used directly
  // because the latched copies are only being written on that same edge.
  assign do_access = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

  assign a_we     = (state == IDLE) ? req_we     : l_we;
  assign a_funct3 = (state == IDLE) ? req_funct3 : l_funct3;
  assign a_addr   = (state == IDLE) ? req_addr   : l_addr;
  assign a_wdata  = (state == IDLE) ? req_wdata  : l_wdata;

  assign word_idx = a_addr[ADDR_W-1:2];
  assign cur_word = mem[word_idx];

  // Lane decode, load extension and store byte enables for the access.
  // Halfword and word accesses always use their naturally aligned lane;
  // when misalignment checking is enabled those accesses are discarded
  // anyway, so the lane choice never matters for them.
  always_comb begin
    illegal = a_we ? (a_funct3 > 3'd2)
                   : ((a_funct3 == 3'b011) || (a_funct3[2:1] == 2'b11));

    case (a_funct3[1:0])
      2'b00:   begin eff_off = a_addr[1:0];        be = 4'b0001 << a_addr[1:0]; end
      2'b01:   begin eff_off = {a_addr[1], 1'b0};  be = a_addr[1] ? 4'b1100 : 4'b0011; end
      default: begin eff_off = 2'b00;              be = 4'b1111; end
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    bad = illegal ||
          ((a_funct3[1:0] == 2'b01) && a_addr[0]) ||
          ((a_funct3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    acc_err = bad;
`else
    bad     = illegal;
    acc_err = 1'b0;
`endif

    shifted = cur_word >> {eff_off, 3'b000};
    wshift  = a_wdata << {eff_off, 3'b000};

    case (a_funct3[1:0])
      2'b00:   ld_data = a_funct3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = a_funct3[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
    if (a_we || bad) ld_data = '0;

    wr_en = do_access && a_we && !bad && !reset;
  end

  // Memory array: deliberately not reset, contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_funct3  <= 3'd0;
      l_addr    <= '0;
      l_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_we      <= req_we;
            l_funct3  <= req_funct3;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= ld_data;
              rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
            rsp_err   <= acc_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY = 2).
// A byte-addressed reference memory produces the expected response of each
// request; the expectation is queued when the request is driven and popped
// when the responder raises rsp_valid. Expectations follow the
// DMEM_MISALIGN_CHECK_EN setting of the build.

module tb_dmem_responder;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [0:(1<<ADDR_W)-1];
  logic [32:0] expq [$];

  dmem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory, returns {err, rdata}.
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, output logic [32:0] result);
    logic illegal;
    logic bad;
    int nbytes;
    int base;
    logic [31:0] v;
    illegal = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base = int'(addr);
    if (nbytes == 2) base = base & ~1;
    if (nbytes == 4) base = base & ~3;
`ifdef DMEM_MISALIGN_CHECK_EN
    bad = illegal || (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
    result = {bad, 32'h0};
`else
    bad = illegal;
    result = 33'h0;
`endif
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) mdl[base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mdl[base + i];
        if (!f3[2] && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
        result[31:0] = v;
      end
    end
  endtask

  // Issue one request, wait for its response, hold it for 'hold' cycles
  // with rsp_ready low, then consume it.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata, input int hold);
    logic [32:0] res;
    logic [32:0] exp;
    logic [31:0] snap;
    int edges;
    @(negedge clk);
    checkOutput("ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; rsp_ready = 1'b0;
    modelAccess(we, f3, addr, wdata, res);
    expq.push_back(res);
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(LATENCY));
    exp = expq.pop_front();
    checkOutput("rdata", rsp_rdata, exp[31:0]);
    checkOutput("err", 32'(rsp_err), 32'(exp[32]));
    checkOutput("ready_busy", 32'(req_ready), 32'd0);
    snap = rsp_rdata;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rdata", rsp_rdata, snap);
      checkOutput("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("consumed_valid", 32'(rsp_valid), 32'd0);
    checkOutput("consumed_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [32:0] dummy;
    logic [2:0] f3;
    logic we;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

    // Directed word/byte/half sequence.
    applyStimulus(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 0);
    applyStimulus(1'b0, 3'b010, 9'h010, 32'h0, 0);
    applyStimulus(1'b1, 3'b000, 9'h011, 32'h0000007F, 0);
    applyStimulus(1'b0, 3'b000, 9'h011, 32'h0, 0);
    applyStimulus(1'b0, 3'b100, 9'h013, 32'h0, 0);
    applyStimulus(1'b0, 3'b001, 9'h012, 32'h0, 0);
    applyStimulus(1'b0, 3'b101, 9'h012, 32'h0, 0);
    applyStimulus(1'b0, 3'b000, 9'h013, 32'h0, 0);
    // Misaligned word load.
    applyStimulus(1'b0, 3'b010, 9'h011, 32'h0, 0);
    // Backpressure: response held for 5 cycles.
    applyStimulus(1'b0, 3'b010, 9'h010, 32'h0, 5);

    // Reset pulsed while a store is still in WAIT: the store is dropped.
    applyStimulus(1'b1, 3'b010, 9'h020, 32'hA5A5A5A5, 0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("wait_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rdata", rsp_rdata, 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 3'b010, 9'h020, 32'h0, 0);

    // Illegal funct3 codes for a load and a store.
    applyStimulus(1'b1, 3'b010, 9'h044, 32'h0BADF00D, 0);
    applyStimulus(1'b0, 3'b011, 9'h044, 32'h0, 0);
    applyStimulus(1'b0, 3'b110, 9'h044, 32'h0, 0);
    applyStimulus(1'b1, 3'b101, 9'h044, 32'hFFFFFFFF, 0);
    applyStimulus(1'b0, 3'b010, 9'h044, 32'h0, 0);

    // Random mix over an initialised window.
    for (int w = 0; w < 8; w++)
      applyStimulus(1'b1, 3'b010, 9'(9'h040 + 4*w), $urandom, 0);
    for (int n = 0; n < 30; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = we ? 3'b000 : 3'b100;
        default: f3 = we ? 3'b001 : 3'b101;
      endcase
      applyStimulus(we, f3, 9'(9'h040 + $urandom_range(0, 31)), $urandom, $urandom_range(0, 2));
    end

    if (expq.size() != 0) modelAccess(1'b0, 3'b010, 9'h040, 32'h0, dummy);
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
